final_key_in_pio: RTL and testbench

//  Avalon-MM slave input port: the read-direction counterpart of the system's output PIOs.

---
 rtl/final_pio_pkg.sv | 22 ++
 rtl/final_key_debounce.sv | 51 +++++
 rtl/final_key_in_pio.sv | 97 +++++++++
 tb/tb_final_key_in_pio.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/final_pio_pkg.sv
// Shared register map and edge-select encodings for the key input PIO.
package final_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  function automatic logic edge_sel(input logic rise, input logic fall, input int edge_type);
    logic sel;
    case (edge_type)
      EDGE_RISE: sel = rise;
      EDGE_FALL: sel = fall;
      default:   sel = rise | fall;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/final_key_debounce.sv
// One input bit: 2-flop synchroniser followed by a stable-run debouncer.
module final_key_debounce #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_i,
  output logic deb_o
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          deb_q;
  logic          deb_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // The run that would reach DEB_CYCLES flips deb instead, so the counter
  // tops out at DEB_CYCLES-1 and cannot wrap.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = ~deb_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= in_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/final_key_in_pio.sv
// Avalon-MM key input PIO: debounced data, edge capture (write-1-to-clear),
// interrupt mask and a masked level interrupt.
module final_key_in_pio
  import final_pio_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int DEB_CYCLES = 50000,
  parameter int EDGE_TYPE  = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] deb_d1_q;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] edgecap_q;
  logic [WIDTH-1:0] edgecap_d;
  logic [WIDTH-1:0] irqmask_q;
  logic [WIDTH-1:0] irqmask_d;
  logic [31:0]      readdata_q;
  logic [31:0]      readdata_d;
  logic             wr_mask;
  logic             wr_edge;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      final_key_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
      ) u_deb (
        .clk    (clk),
        .reset_n(reset_n),
        .in_i   (in_port[gi]),
        .deb_o  (deb[gi])
      );

      assign edge_det[gi] = edge_sel(deb[gi] & ~deb_d1_q[gi], ~deb[gi] & deb_d1_q[gi], EDGE_TYPE);
    end

    if (WIDTH < 32) begin : g_unused
      logic unused_wdata;
      assign unused_wdata = ^writedata[31:WIDTH];
    end
  endgenerate

  assign wr_mask = chipselect & ~write_n & (address == PIO_ADDR_MASK);
  assign wr_edge = chipselect & ~write_n & (address == PIO_ADDR_EDGE);

  always_comb begin
    irqmask_d = irqmask_q;
    if (wr_mask) begin
      irqmask_d = writedata[WIDTH-1:0];
    end
    // A fresh edge is OR'ed in after the clear so it is never lost.
    edgecap_d = edgecap_q;
    if (wr_edge) begin
      edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
    end
    edgecap_d = edgecap_d | edge_det;
  end

  always_comb begin
    readdata_d = 32'h0;
    case (address)
      PIO_ADDR_DATA: readdata_d = 32'(deb);
      PIO_ADDR_MASK: readdata_d = 32'(irqmask_q);
      PIO_ADDR_EDGE: readdata_d = 32'(edgecap_q);
      default:       readdata_d = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_d1_q   <= '0;
      edgecap_q  <= '0;
      irqmask_q  <= '0;
      readdata_q <= '0;
    end else begin
      deb_d1_q   <= deb;
      edgecap_q  <= edgecap_d;
      irqmask_q  <= irqmask_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_final_key_in_pio.sv
// Self-checking bench for final_key_in_pio (WIDTH=4, DEB_CYCLES=4, falling edges).
module tb_final_key_in_pio;

  localparam int DEB = 4;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  in_port;
  logic        irq;

  int n_pass;
  int n_total;

  final_key_in_pio #(
    .WIDTH(4),
    .DEB_CYCLES(DEB),
    .EDGE_TYPE(1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a debounced bit flips once the last DEB synchronised
  // samples all disagree with it; a 1->0 flip is captured one cycle later.
  logic [3:0]  m_hist [0:7];
  logic [3:0]  m_deb;
  logic [3:0]  m_mask;
  logic [3:0]  m_edge;
  logic [3:0]  m_fall_pending;
  logic [31:0] m_rd;
  logic        m_irq;

  assign m_irq = |(m_edge & m_mask);

  always @(posedge clk or negedge reset_n) begin
    logic [3:0] nd;
    logic [3:0] clr;
    logic       all_differ;
    if (!reset_n) begin
      for (int k = 0; k < 8; k++) m_hist[k] <= 4'h0;
      m_deb          <= 4'h0;
      m_mask         <= 4'h0;
      m_edge         <= 4'h0;
      m_fall_pending <= 4'h0;
      m_rd           <= 32'h0;
    end else begin
      nd = m_deb;
      for (int b = 0; b < 4; b++) begin
        all_differ = 1'b1;
        for (int k = 1; k <= DEB; k++) begin
          if (m_hist[k][b] == m_deb[b]) all_differ = 1'b0;
        end
        if (all_differ) nd[b] = ~m_deb[b];
      end
      case (address)
        2'd0:    m_rd <= {28'h0, m_deb};
        2'd2:    m_rd <= {28'h0, m_mask};
        2'd3:    m_rd <= {28'h0, m_edge};
        default: m_rd <= 32'h0;
      endcase
      clr = (chipselect && !write_n && address == 2'd3) ? writedata[3:0] : 4'h0;
      m_edge <= (m_edge & ~clr) | m_fall_pending;
      if (chipselect && !write_n && address == 2'd2) m_mask <= writedata[3:0];
      m_fall_pending <= m_deb & ~nd;
      m_deb <= nd;
      for (int k = 7; k > 0; k--) m_hist[k] <= m_hist[k-1];
      m_hist[0] <= in_port;
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic rd(input logic [1:0] a);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    tick(1);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = d;
    tick(1);
    write_n    = 1'b1;
    chipselect = 1'b0;
  endtask

  task automatic test_reset();
    logic [1:0] addrs [0:2];
    addrs[0] = 2'd0; addrs[1] = 2'd2; addrs[2] = 2'd3;
    reset_n = 1'b0;
    in_port = 4'hF;
    tick(2);
    for (int i = 0; i < 3; i++) begin
      rd(addrs[i]);
      n_total++; if (readdata !== 32'h0) $display("FAIL reset_readdata a=%0d: got %h want %h", addrs[i], readdata, 32'h0); else n_pass++;
      n_total++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else n_pass++;
    end
    reset_n = 1'b1;
    tick(6);
    rd(2'd0);
    n_total++; if (readdata !== 32'hF) $display("FAIL reset_release_data: got %h want %h", readdata, 32'hF); else n_pass++;
    rd(2'd3);
    n_total++; if (readdata !== 32'h0) $display("FAIL reset_release_edge: got %h want %h", readdata, 32'h0); else n_pass++;
  endtask

  task automatic test_fall();
    in_port = 4'hD;
    tick(5);
    rd(2'd0);
    n_total++; if (readdata !== 32'hF) $display("FAIL fall_data_early: got %h want %h", readdata, 32'hF); else n_pass++;
    rd(2'd0);
    n_total++; if (readdata !== 32'hD) $display("FAIL fall_data: got %h want %h", readdata, 32'hD); else n_pass++;
    rd(2'd3);
    n_total++; if (readdata !== 32'h2) $display("FAIL fall_edge: got %h want %h", readdata, 32'h2); else n_pass++;
    n_total++; if (irq !== 1'b0) $display("FAIL fall_irq_masked: got %b want 0", irq); else n_pass++;
    wr(2'd2, 32'h2);
    n_total++; if (irq !== 1'b1) $display("FAIL fall_irq_unmasked: got %b want 1", irq); else n_pass++;
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 10; i++) begin
      in_port[2] = ~in_port[2];
      for (int j = 0; j < 2; j++) begin
        rd(2'd0);
        n_total++; if (readdata !== 32'hD) $display("FAIL bounce_data i=%0d: got %h want %h", i, readdata, 32'hD); else n_pass++;
      end
    end
    rd(2'd3);
    n_total++; if (readdata !== 32'h2) $display("FAIL bounce_no_edge: got %h want %h", readdata, 32'h2); else n_pass++;
    in_port[2] = 1'b0;
    tick(6);
    rd(2'd3);
    n_total++; if (readdata !== 32'h2) $display("FAIL bounce_edge_early: got %h want %h", readdata, 32'h2); else n_pass++;
    rd(2'd3);
    n_total++; if (readdata !== 32'h6) $display("FAIL bounce_edge: got %h want %h", readdata, 32'h6); else n_pass++;
  endtask

  task automatic test_w1c();
    wr(2'd3, 32'h2);
    n_total++; if (irq !== 1'b0) $display("FAIL w1c_irq_after_clear: got %b want 0", irq); else n_pass++;
    rd(2'd3);
    n_total++; if (readdata !== 32'h4) $display("FAIL w1c_edge: got %h want %h", readdata, 32'h4); else n_pass++;
    wr(2'd2, 32'h4);
    n_total++; if (irq !== 1'b1) $display("FAIL w1c_irq_mask4: got %b want 1", irq); else n_pass++;
    in_port = 4'hD;
    tick(8);
    in_port = 4'h9;
    tick(6);
    wr(2'd3, 32'h4);
    rd(2'd3);
    n_total++; if (readdata !== 32'h4) $display("FAIL w1c_edge_wins: got %h want %h", readdata, 32'h4); else n_pass++;
    n_total++; if (irq !== 1'b1) $display("FAIL w1c_edge_wins_irq: got %b want 1", irq); else n_pass++;
  endtask

  task automatic test_read_timing();
    rd(2'd3);
    wr(2'd2, 32'h9);
    address    = 2'd2;
    chipselect = 1'b1;
    n_total++; if (readdata !== 32'h4) $display("FAIL rt_before: got %h want %h", readdata, 32'h4); else n_pass++;
    tick(1);
    n_total++; if (readdata !== 32'h9) $display("FAIL rt_mask: got %h want %h", readdata, 32'h9); else n_pass++;
    rd(2'd1);
    n_total++; if (readdata !== 32'h0) $display("FAIL rt_addr1: got %h want %h", readdata, 32'h0); else n_pass++;
    wr(2'd0, 32'hFFFF_FFFF);
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd0);
    n_total++; if (readdata !== 32'h9) $display("FAIL rt_data_kept: got %h want %h", readdata, 32'h9); else n_pass++;
    rd(2'd2);
    n_total++; if (readdata !== 32'h9) $display("FAIL rt_mask_kept: got %h want %h", readdata, 32'h9); else n_pass++;
    rd(2'd3);
    n_total++; if (readdata !== 32'h4) $display("FAIL rt_edge_kept: got %h want %h", readdata, 32'h4); else n_pass++;
    n_total++; if (irq !== 1'b0) $display("FAIL rt_irq: got %b want 0", irq); else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      n_total++; if (readdata !== m_rd) $display("FAIL rand_readdata c=%0d: got %h want %h", c, readdata, m_rd); else n_pass++;
      n_total++; if (irq !== m_irq) $display("FAIL rand_irq c=%0d: got %b want %b", c, irq, m_irq); else n_pass++;
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 5) == 0) in_port[b] = ~in_port[b];
      end
      address    = 2'($urandom_range(0, 3));
      chipselect = ($urandom_range(0, 3) == 0);
      write_n    = 1'($urandom_range(0, 1));
      writedata  = $urandom;
      tick(1);
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic test_mid_reset();
    in_port = 4'hF;
    tick(8);
    in_port = 4'h0;
    tick(8);
    wr(2'd2, 32'h9);
    rd(2'd3);
    n_total++; if (readdata !== 32'hF) $display("FAIL mr_edge_all: got %h want %h", readdata, 32'hF); else n_pass++;
    n_total++; if (irq !== 1'b1) $display("FAIL mr_irq_before: got %b want 1", irq); else n_pass++;
    in_port = 4'hF;
    tick(4);
    #2;
    reset_n = 1'b0;
    #1;
    n_total++; if (irq !== 1'b0) $display("FAIL mr_irq_async: got %b want 0", irq); else n_pass++;
    n_total++; if (readdata !== 32'h0) $display("FAIL mr_readdata_async: got %h want %h", readdata, 32'h0); else n_pass++;
    in_port = 4'h0;
    @(negedge clk);
    tick(3);
    reset_n = 1'b1;
    tick(10);
    rd(2'd0);
    n_total++; if (readdata !== 32'h0) $display("FAIL mr_data_after: got %h want %h", readdata, 32'h0); else n_pass++;
    rd(2'd2);
    n_total++; if (readdata !== 32'h0) $display("FAIL mr_mask_after: got %h want %h", readdata, 32'h0); else n_pass++;
    rd(2'd3);
    n_total++; if (readdata !== 32'h0) $display("FAIL mr_edge_after: got %h want %h", readdata, 32'h0); else n_pass++;
    n_total++; if (irq !== 1'b0) $display("FAIL mr_irq_after: got %b want 0", irq); else n_pass++;
  endtask

  initial begin
    n_pass     = 0;
    n_total    = 0;
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in_port    = 4'hF;
    @(negedge clk);
    test_reset();
    test_fall();
    test_bounce();
    test_w1c();
    test_read_timing();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
